// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared event codes, FSM states and default timing for the key event controller
package key_pkg;

  localparam logic [1:0] EVT_NONE   = 2'd0;
  localparam logic [1:0] EVT_SHORT  = 2'd1;
  localparam logic [1:0] EVT_LONG   = 2'd2;
  localparam logic [1:0] EVT_REPEAT = 2'd3;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_LONG    = 2'd3
  } key_state_e;

  // 1.5 s hold and 200 ms repeat at 50 MHz
  localparam int unsigned LONG_CNT_DEF   = 32'd75000000;
  localparam int unsigned REPEAT_CNT_DEF = 32'd10000000;

endpackage

// File: rtl/key_press_fsm.sv
// rtl/key_press_fsm.sv - per-key press timing FSM with a one-entry pending event slot
module key_press_fsm
  import key_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
  parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_s_i,
  input  logic       arm_en_i,
  input  logic       clr_i,
  output logic       pend_full_o,
  output logic [1:0] pend_code_o,
  output logic       ovf_o
);

  // hold_q lags the press-cycle index by one, hence LONG_CNT-2
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CNT - 32'd2);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 32'd1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             full_q, full_d;
  logic [1:0]       code_q, code_d;
  logic             ovf_q, ovf_d;
  logic             emit;
  logic [1:0]       emit_code;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    emit      = 1'b0;
    emit_code = EVT_NONE;
    unique case (state_q)
      ST_ARM: begin
        if (arm_en_i && key_s_i) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!key_s_i) begin
          state_d = ST_PRESSED;
          hold_d  = '0;
        end
      end
      ST_PRESSED: begin
        if (key_s_i) begin
          emit      = 1'b1;
          emit_code = EVT_SHORT;
          state_d   = ST_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_LONG;
          state_d   = ST_LONG;
          rep_d     = '0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (key_s_i) begin
          state_d = ST_IDLE;
        end else if (rep_q == REP_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_REPEAT;
          rep_d     = '0;
        end else begin
          rep_d = rep_q + CNT_W'(1);
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  // A grant frees the slot before this cycle's emit is considered
  always_comb begin
    full_d = full_q & ~clr_i;
    code_d = code_q;
    ovf_d  = ovf_q;
    if (emit) begin
      if (full_d) begin
        ovf_d = 1'b1;
      end else begin
        full_d = 1'b1;
        code_d = emit_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARM;
      hold_q  <= '0;
      rep_q   <= '0;
      full_q  <= 1'b0;
      code_q  <= EVT_NONE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      full_q  <= full_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pend_full_o = full_q;
  assign pend_code_o = code_q;
  assign ovf_o       = ovf_q;

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - turns debounced key levels into SHORT/LONG/REPEAT events on one valid/ready port
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int          NUM_KEYS   = 4,
  parameter int          CNT_W      = 32,
  parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
  parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_lvl,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [2:0]          evt_key,
  output logic [1:0]          evt_code,
  output logic [NUM_KEYS-1:0] evt_ovf
);

  logic [NUM_KEYS-1:0]      key_s_q;
  logic                     key_s_vld_q;
  logic [NUM_KEYS-1:0]      pend_full;
  logic [NUM_KEYS-1:0][1:0] pend_code;
  logic [NUM_KEYS-1:0]      clr;

  logic       valid_q, valid_d;
  logic [2:0] key_q, key_d;
  logic [1:0] code_q, code_d;
  logic [2:0] ptr_q, ptr_d;

  logic [7:0]      full_ext;
  logic [7:0][1:0] code_ext;
  logic [7:0]      clr_ext;
  logic [3:0]      sum;
  logic [2:0]      gnt_idx;
  logic            found;
  logic            grant;

  // key_s_vld_q keeps ARM from trusting the reset value of key_s_q,
  // otherwise a debouncer stuck at 0 would look released then pressed
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_press_fsm #(
      .CNT_W      (CNT_W),
      .LONG_CNT   (LONG_CNT),
      .REPEAT_CNT (REPEAT_CNT)
    ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .key_s_i     (key_s_q[k]),
      .arm_en_i    (key_s_vld_q),
      .clr_i       (clr[k]),
      .pend_full_o (pend_full[k]),
      .pend_code_o (pend_code[k]),
      .ovf_o       (evt_ovf[k])
    );
  end

  always_comb begin
    full_ext = '0;
    code_ext = '0;
    full_ext[NUM_KEYS-1:0] = pend_full;
    for (int k = 0; k < NUM_KEYS; k++) code_ext[k] = pend_code[k];
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int off = 0; off < NUM_KEYS; off++) begin
      sum = {1'b0, ptr_q} + 4'(off);
      if (sum >= 4'(NUM_KEYS)) sum = sum - 4'(NUM_KEYS);
      if (!found && full_ext[sum[2:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[2:0];
      end
    end
  end

  assign grant   = found & (~valid_q | evt_ready);
  assign clr_ext = grant ? (8'd1 << gnt_idx) : 8'd0;
  assign clr     = clr_ext[NUM_KEYS-1:0];

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    code_d  = code_q;
    ptr_d   = ptr_q;
    if (grant) begin
      valid_d = 1'b1;
      key_d   = gnt_idx;
      code_d  = code_ext[gnt_idx];
      ptr_d   = (gnt_idx == 3'(NUM_KEYS - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end else if (evt_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_s_q     <= '1;
      key_s_vld_q <= 1'b0;
      valid_q     <= 1'b0;
      key_q       <= '0;
      code_q      <= EVT_NONE;
      ptr_q       <= '0;
    end else begin
      key_s_q     <= key_lvl;
      key_s_vld_q <= 1'b1;
      valid_q     <= valid_d;
      key_q       <= key_d;
      code_q      <= code_d;
      ptr_q       <= ptr_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_key   = key_q;
  assign evt_code  = code_q;

endmodule
